tl_ad_inflight_monitor: RTL
===========================

# tl_ad_inflight_monitor

Parametrised, cycle-accurate TileLink-UL A/D channel protocol checker that tracks outstanding requests per source ID. It replaces the single-condition combinational `$fatal` checks with registered error reporting, per-source inflight tracking, multi-beat burst checking and a response watchdog. It sits beside any TL-UL repeater or crossbar port as a passive monitor; it never drives the bus.

## Interface
Parameters:
- DATA_BYTES, 4: bus width in bytes; power of two, ≥1; LG_DB = log2(DATA_BYTES).
- SOURCE_BITS, 2: source ID width; SOURCES = 2^SOURCE_BITS.
- SIZE_BITS, 3: width of the size fields.
- TIMEOUT, 1024: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid, a_ready  in  1  A channel handshake; A fires when both are 1.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- a_size  in  SIZE_BITS  log2 of the transfer bytes.
- a_source  in  SOURCE_BITS  request ID.
- a_mask  in  DATA_BYTES  byte mask.
- d_valid, d_ready  in  1  D channel handshake; D fires when both are 1.
- d_opcode  in  3  0=AccessAck, 1=AccessAckData.
- d_size  in  SIZE_BITS; d_source  in  SOURCE_BITS.
- err_pulse  out  1  one-cycle pulse when any error is detected.
- err_code  out  3  index of the lowest-numbered error in that pulse; holds its value until the next pulse.
- err_sticky  out  6  OR-accumulated error bits; cleared only by reset.
- inflight_cnt  out  SOURCE_BITS+1  number of outstanding sources.

## Operation
- Beat count: beats(size) = 2^(size−LG_DB) if size > LG_DB, else 1.
  - A is multi-beat only for Put opcodes.
  - D is multi-beat only for AccessAckData.
- Per-channel beat counters track position in the current burst.
  - first = counter==0; last = counter==beats−1.
  - On a fire, the counter increments, or wraps to 0 on last.
  - On an A first beat, opcode, size and source are latched for the burst-stability check.
- Per-source state: inflight bit, expected response (AckData for Get, Ack for Put*), and recorded size.
  - Set on A first-beat fire.
  - Cleared on D last-beat fire.
  - D last and A first for the same source in the same cycle: this is legal, not A_DUP. The bit stays set and the new request's fields are recorded.
- Error bits, evaluated on fires:
  - 0 A_MASK: PutFullData beat with size ≥ LG_DB and a_mask ≠ all ones. For size < LG_DB, mask popcount must equal 2^size.
  - 1 A_DUP: A first beat whose source is already inflight (after the same-cycle clear rule).
  - 2 A_BURST: A non-first beat whose opcode, size or source differs from the latched values.
  - 3 D_ORPHAN: D first beat whose source is not inflight.
  - 4 D_MISMATCH: D first beat whose opcode ≠ expected or d_size ≠ recorded size. Not checked when D_ORPHAN fires.
  - 5 TIMEOUT: watchdog expiry.
- Watchdog counter:
  - Resets to 0 on any D fire or when inflight_cnt==0; otherwise increments.
  - On reaching TIMEOUT it raises TIMEOUT once, then saturates until its reset condition.
- Errors never alter the tracking state; counters and inflight bits update as if the traffic were legal.

## Timing
- All outputs are registered.
- Reset values: err_pulse=0, err_code=0, err_sticky=0, inflight_cnt=0. Beat counters, inflight bits and the watchdog are also 0.
- Error latency: an offending fire in cycle N gives err_pulse=1 in cycle N+1.
  - Multiple errors in one cycle: all set in err_sticky; err_code reports the lowest index.
- inflight_cnt reflects a fire in cycle N in cycle N+1. A simultaneous set and clear of different sources leaves it unchanged.
- Asserting reset_n low mid-burst clears all state immediately. After release, traffic restarts at a first beat.

## Test plan
- DATA_BYTES=4. Get, size 2, source 1 → inflight_cnt=1. Then AccessAckData, size 2, source 1 → inflight_cnt=0, err_sticky=0.
- PutFull, size 4: 4 beats, mask 0xF, source 0. Beat 3 uses source 2 → err_pulse, err_code=2, err_sticky=0x04. AccessAck, size 4 then clears source 0.
- Get source 3, then a second Get source 3 before D → err_code=1. D AccessAck for source 3 → err_code=4 (expected AckData).
- D fire with source 2 when idle → err_code=3, err_sticky bit 3. A PutFull, size 2, mask 0x7 in the same cycle → err_code=0, err_sticky=0x09.
- TIMEOUT=16, one Get with no D → err_pulse in exactly one cycle, at the 16th cycle after the fire, err_code=5. No further pulse occurs while still stalled.
- Reset asserted mid 4-beat Put → all outputs 0. New Get then completes cleanly with no errors.

Source files
------------

// File: rtl/tl_ad_inflight_monitor.sv
// tl_ad_inflight_monitor: passive TileLink-UL A/D channel protocol checker.
// Tracks outstanding requests per source ID, burst beat positions on both
// channels and a response watchdog. Protocol errors are reported as a
// registered one-cycle pulse plus a sticky accumulation of error bits.

module tl_ad_inflight_monitor #(
  parameter int DATA_BYTES  = 4,
  parameter int SOURCE_BITS = 2,
  parameter int SIZE_BITS   = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [DATA_BYTES-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_pulse,
  output logic [2:0]             err_code,
  output logic [5:0]             err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int LG_DB   = $clog2(DATA_BYTES);
  localparam int SOURCES = 1 << SOURCE_BITS;
  // A beat index never exceeds 2^(2^SIZE_BITS - 1) - 1, so this width always fits.
  localparam int BW      = 1 << SIZE_BITS;
  localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_W   = SOURCE_BITS + 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  // Index of the final beat of a burst; single-beat messages end at index 0.
  function automatic logic [BW-1:0] last_beat(input logic [SIZE_BITS-1:0] size,
                                               input logic multi);
    last_beat = '0;
    if (multi && (int'(size) > LG_DB))
      last_beat = BW'((1 << (int'(size) - LG_DB)) - 1);
  endfunction

  logic                   a_fire, d_fire;
  logic                   a_multi, d_multi;
  logic                   a_first, a_last, d_first, d_last;
  logic [BW-1:0]          a_cnt, d_cnt;
  logic [2:0]             lat_op;
  logic [SIZE_BITS-1:0]   lat_size;
  logic [SOURCE_BITS-1:0] lat_src;
  logic [SOURCES-1:0]     inflight, inflight_nx;
  logic [SOURCES-1:0]     exp_data, exp_data_nx;
  logic [SIZE_BITS-1:0]   rec_size    [SOURCES];
  logic [SIZE_BITS-1:0]   rec_size_nx [SOURCES];
  logic [WD_W-1:0]        wd, wd_nx;
  logic                   wd_hit;
  logic                   mask_bad;
  logic [5:0]             err_nx;
  logic [2:0]             code_nx;

  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_multi = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign d_multi = (d_opcode == OP_ACK_DATA);
  assign a_first = (a_cnt == '0);
  assign d_first = (d_cnt == '0);
  // Using >= lets a burst whose size changed mid-flight still wrap back to a first beat.
  assign a_last  = (a_cnt >= last_beat(a_size, a_multi));
  assign d_last  = (d_cnt >= last_beat(d_size, d_multi));

  // Byte-mask legality for PutFullData: full lanes for wide transfers, 2^size lanes for narrow ones.
  always_comb begin
    mask_bad = 1'b0;
    if (a_opcode == OP_PUT_FULL) begin
      if (int'(a_size) >= LG_DB)
        mask_bad = (a_mask != '1);
      else
        mask_bad = ($countones(a_mask) != (1 << int'(a_size)));
    end
  end

  // Next per-source tracking state; a same-cycle D-last clear is applied before the A-first set.
  always_comb begin
    inflight_nx = inflight;
    exp_data_nx = exp_data;
    rec_size_nx = rec_size;
    if (d_fire && d_last)
      inflight_nx[d_source] = 1'b0;
    if (a_fire && a_first) begin
      inflight_nx[a_source] = 1'b1;
      exp_data_nx[a_source] = (a_opcode == OP_GET);
      rec_size_nx[a_source] = a_size;
    end
  end

  // Watchdog: counts stalled cycles while anything is outstanding, flags once on reaching the limit.
  always_comb begin
    wd_nx  = wd;
    wd_hit = 1'b0;
    if ((TIMEOUT == 0) || d_fire || (inflight_nx == '0)) begin
      wd_nx = '0;
    end else if (wd != WD_W'(TIMEOUT)) begin
      wd_nx  = wd + WD_W'(1);
      wd_hit = (wd_nx == WD_W'(TIMEOUT));
    end
  end

  // Error detection for this cycle's fires and the lowest-numbered error among them.
  always_comb begin
    err_nx    = '0;
    err_nx[0] = a_fire && mask_bad;
    err_nx[1] = a_fire && a_first && inflight[a_source] &&
                !(d_fire && d_last && (d_source == a_source));
    err_nx[2] = a_fire && !a_first &&
                ((a_opcode != lat_op) || (a_size != lat_size) || (a_source != lat_src));
    err_nx[3] = d_fire && d_first && !inflight[d_source];
    err_nx[4] = d_fire && d_first && inflight[d_source] &&
                ((d_opcode != (exp_data[d_source] ? OP_ACK_DATA : OP_ACK)) ||
                 (d_size != rec_size[d_source]));
    err_nx[5] = wd_hit;
    code_nx   = '0;
    for (int i = 5; i >= 0; i--)
      if (err_nx[i]) code_nx = 3'(i);
  end

  // Beat counters and the first-beat latch used for burst stability checks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt    <= '0;
      d_cnt    <= '0;
      lat_op   <= '0;
      lat_size <= '0;
      lat_src  <= '0;
    end else begin
      if (a_fire)
        a_cnt <= a_last ? '0 : a_cnt + BW'(1);
      if (d_fire)
        d_cnt <= d_last ? '0 : d_cnt + BW'(1);
      if (a_fire && a_first) begin
        lat_op   <= a_opcode;
        lat_size <= a_size;
        lat_src  <= a_source;
      end
    end
  end

  // Per-source inflight table and the watchdog counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
      exp_data <= '0;
      for (int i = 0; i < SOURCES; i++)
        rec_size[i] <= '0;
      wd <= '0;
    end else begin
      inflight <= inflight_nx;
      exp_data <= exp_data_nx;
      rec_size <= rec_size_nx;
      wd       <= wd_nx;
    end
  end

  // Registered error reporting and outstanding-source count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse    <= 1'b0;
      err_code     <= '0;
      err_sticky   <= '0;
      inflight_cnt <= '0;
    end else begin
      err_pulse  <= |err_nx;
      if (|err_nx)
        err_code <= code_nx;
      err_sticky   <= err_sticky | err_nx;
      inflight_cnt <= CNT_W'($countones(inflight_nx));
    end
  end

endmodule
